// File: rtl/agc_pkg.sv
// agc_pkg: shared register-file types and default sizes for the AGC core
package agc_pkg;
   localparam int WIDTH    = 15;
   localparam int NREGS    = 8;
   localparam int ZERO_IDX = 7;
   typedef enum logic [2:0] {R0, R1, R2, R3, R4, R5, R6, ZERO} reg_t;
endpackage

// File: rtl/agc_scoreboard_regfile_pending_counter.sv
// pending_counter: saturating per-register count of outstanding writes
module pending_counter #(
   parameter int CNT_W = 2,
   parameter int IW    = 2
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             clear,
   input  logic [IW-1:0]    inc,
   input  logic [IW-1:0]    dec,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf_pulse
);
   localparam int PMAX = 2**CNT_W - 1;
   int nxt;
   logic [CNT_W-1:0] cnt_n;
   // Whole delta applied at once; going below zero is a legal untracked write
   always_comb begin
      nxt = int'(cnt) + int'(inc) - int'(dec);
      ovf_pulse = nxt > PMAX;
      cnt_n = nxt < 0 ? '0 : ovf_pulse ? CNT_W'(PMAX) : CNT_W'(nxt);
   end
   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) cnt <= '0;
      else cnt <= clear ? '0 : cnt_n;
endmodule

// File: rtl/agc_scoreboard_regfile.sv
// agc_scoreboard_regfile: multi-port register file with pending-write scoreboard and decode stall
module agc_scoreboard_regfile
   import agc_pkg::*;
#(
   parameter int WIDTH    = agc_pkg::WIDTH,
   parameter int NREGS    = agc_pkg::NREGS,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_IDX = agc_pkg::ZERO_IDX,
   parameter int BYPASS   = 1,
   parameter int CNT_W    = 2,
   localparam int AW      = $clog2(NREGS),
   localparam int IW      = $clog2(NWR + 1)
) (
   input  logic                      clk,
   input  logic                      rst_l,
   input  logic                      clear,
   input  logic [NWR-1:0]            wr_en,
   input  logic [NWR-1:0][AW-1:0]    wr_sel,
   input  logic [NWR-1:0][WIDTH-1:0] wr_data,
   input  logic [NWR-1:0]            rsv_en,
   input  logic [NWR-1:0][AW-1:0]    rsv_sel,
   input  logic [NRD-1:0]            rd_req,
   input  logic [NRD-1:0][AW-1:0]    rd_sel,
   output logic [NRD-1:0][WIDTH-1:0] rd_data,
   output logic [NRD-1:0]            rd_busy,
   output logic                      stall,
   output logic                      ovf
);
   logic [NREGS-1:0][WIDTH-1:0] mem;
   logic [NREGS-1:0][IW-1:0]    inc, dec;
   logic [NREGS-1:0][CNT_W-1:0] cnt;
   logic [NREGS-1:0]            ovf_p;
   // Later ports overwrite earlier ones, so the highest-indexed writer wins
   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) mem <= '0;
      else if (clear) mem <= '0;
      else
         for (int p = 0; p < NWR; p++)
            if (wr_en[p] && wr_sel[p] != AW'(ZERO_IDX)) mem[wr_sel[p]] <= wr_data[p];
   always_comb begin
      inc = '0;
      dec = '0;
      for (int r = 0; r < NREGS; r++)
         for (int p = 0; p < NWR; p++) begin
            if (r != ZERO_IDX && rsv_en[p] && rsv_sel[p] == AW'(r)) inc[r] = inc[r] + IW'(1);
            if (r != ZERO_IDX && wr_en[p] && wr_sel[p] == AW'(r)) dec[r] = dec[r] + IW'(1);
         end
   end
   for (genvar g = 0; g < NREGS; g++) begin : g_cnt
      pending_counter #(.CNT_W(CNT_W), .IW(IW)) u_cnt (
         .clk       (clk),
         .rst_l     (rst_l),
         .clear     (clear),
         .inc       (inc[g]),
         .dec       (dec[g]),
         .cnt       (cnt[g]),
         .ovf_pulse (ovf_p[g])
      );
   end
   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) ovf <= 1'b0;
      else ovf <= !clear && (ovf || |ovf_p);
   // A writeback retiring the last pending write frees the register in the same cycle
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_data[i] = mem[rd_sel[i]];
         rd_busy[i] = BYPASS != 0 ? int'(cnt[rd_sel[i]]) > int'(dec[rd_sel[i]]) : cnt[rd_sel[i]] != '0;
         if (BYPASS != 0)
            for (int p = 0; p < NWR; p++)
               if (wr_en[p] && wr_sel[p] == rd_sel[i]) rd_data[i] = wr_data[p];
         if (rd_sel[i] == AW'(ZERO_IDX)) begin
            rd_data[i] = '0;
            rd_busy[i] = 1'b0;
         end
      end
   end
   assign stall = |(rd_req & rd_busy);
endmodule

// File: tb/tb_agc_scoreboard_regfile.sv
// tb_agc_scoreboard_regfile: table-driven directed check of the scoreboard register file
module tb_agc_scoreboard_regfile;
   logic clk = 1'b0, rst_l = 1'b0, clear = 1'b0;
   logic [1:0] wr_en, rsv_en, rd_req, rd_busy;
   logic [1:0][2:0] wr_sel, rsv_sel, rd_sel;
   logic [1:0][14:0] wr_data, rd_data;
   logic stall, ovf;
   int checks = 0, errors = 0;

   typedef struct {
      logic clr;
      logic [1:0] we;
      logic [2:0] ws0, ws1;
      logic [14:0] wd0, wd1;
      logic [1:0] re;
      logic [2:0] rs0, rs1;
      logic [1:0] rq;
      logic [2:0] q0, q1;
      logic [14:0] ed0, ed1;
      logic [1:0] eb;
      logic es, eo;
   } vec_t;
   vec_t vecs[$];

   agc_scoreboard_regfile dut (
      .clk(clk), .rst_l(rst_l), .clear(clear),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_sel(rsv_sel),
      .rd_req(rd_req), .rd_sel(rd_sel),
      .rd_data(rd_data), .rd_busy(rd_busy), .stall(stall), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic vec_t v(logic clr, logic [1:0] we, logic [2:0] ws0, logic [2:0] ws1,
                              logic [14:0] wd0, logic [14:0] wd1, logic [1:0] re, logic [2:0] rs0,
                              logic [2:0] rs1, logic [1:0] rq, logic [2:0] q0, logic [2:0] q1,
                              logic [14:0] ed0, logic [14:0] ed1, logic [1:0] eb, logic es, logic eo);
      vec_t t;
      t.clr = clr; t.we = we; t.ws0 = ws0; t.ws1 = ws1; t.wd0 = wd0; t.wd1 = wd1;
      t.re = re; t.rs0 = rs0; t.rs1 = rs1; t.rq = rq; t.q0 = q0; t.q1 = q1;
      t.ed0 = ed0; t.ed1 = ed1; t.eb = eb; t.es = es; t.eo = eo;
      return t;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      clear = 1'b0; wr_en = '0; wr_sel = '0; wr_data = '0;
      rsv_en = '0; rsv_sel = '0; rd_req = '0; rd_sel = '0;
   endtask

   initial begin
      //         clr we    ws0 ws1 wd0      wd1      re    rs0 rs1 rq    q0 q1 ed0      ed1      eb    es eo
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b00, 0, 0, 2'b00, 0, 1, 15'h0,    15'h0,    2'b00, 0, 0));
      vecs.push_back(v(0, 2'b01, 7, 0, 15'h1234, 15'h0,    2'b00, 0, 0, 2'b11, 7, 7, 15'h0,    15'h0,    2'b00, 0, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b00, 0, 0, 2'b11, 7, 7, 15'h0,    15'h0,    2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 2, 2, 15'h0AAA, 15'h0555, 2'b00, 0, 0, 2'b11, 2, 2, 15'h0555, 15'h0555, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b00, 0, 0, 2'b11, 2, 2, 15'h0555, 15'h0555, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b01, 3, 0, 2'b01, 3, 2, 15'h0,    15'h0555, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b00, 0, 0, 2'b01, 3, 3, 15'h0,    15'h0,    2'b11, 1, 0));
      vecs.push_back(v(0, 2'b10, 0, 3, 15'h0,    15'h0042, 2'b00, 0, 0, 2'b01, 3, 3, 15'h0042, 15'h0042, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b00, 0, 0, 2'b11, 3, 3, 15'h0042, 15'h0042, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b01, 1, 0, 2'b10, 0, 1, 15'h0,    15'h0,    2'b00, 0, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b01, 1, 0, 2'b10, 0, 1, 15'h0,    15'h0,    2'b10, 1, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b01, 1, 0, 2'b10, 0, 1, 15'h0,    15'h0,    2'b10, 1, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b01, 1, 0, 2'b10, 0, 1, 15'h0,    15'h0,    2'b10, 1, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b00, 0, 0, 2'b10, 0, 1, 15'h0,    15'h0,    2'b10, 1, 1));
      vecs.push_back(v(0, 2'b01, 1, 0, 15'h0011, 15'h0,    2'b00, 0, 0, 2'b10, 1, 1, 15'h0011, 15'h0011, 2'b11, 1, 1));
      vecs.push_back(v(0, 2'b01, 1, 0, 15'h0022, 15'h0,    2'b00, 0, 0, 2'b10, 1, 1, 15'h0022, 15'h0022, 2'b11, 1, 1));
      vecs.push_back(v(0, 2'b01, 1, 0, 15'h0033, 15'h0,    2'b00, 0, 0, 2'b10, 1, 1, 15'h0033, 15'h0033, 2'b00, 0, 1));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b00, 0, 0, 2'b11, 1, 1, 15'h0033, 15'h0033, 2'b00, 0, 1));
      vecs.push_back(v(1, 2'b01, 2, 0, 15'h7777, 15'h0,    2'b00, 0, 0, 2'b11, 1, 1, 15'h0033, 15'h0033, 2'b00, 0, 1));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b00, 0, 0, 2'b11, 1, 2, 15'h0,    15'h0,    2'b00, 0, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b01, 4, 0, 2'b00, 4, 4, 15'h0,    15'h0,    2'b00, 0, 0));
      vecs.push_back(v(0, 2'b01, 4, 0, 15'h0044, 15'h0,    2'b01, 4, 0, 2'b00, 4, 4, 15'h0044, 15'h0044, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b00, 0, 0, 2'b00, 4, 4, 15'h0044, 15'h0044, 2'b11, 0, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b00, 0, 0, 2'b10, 4, 4, 15'h0044, 15'h0044, 2'b11, 1, 0));
      vecs.push_back(v(0, 2'b01, 4, 0, 15'h0045, 15'h0,    2'b00, 0, 0, 2'b11, 4, 4, 15'h0045, 15'h0045, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b00, 0, 0, 15'h0,    15'h0,    2'b00, 0, 0, 2'b11, 4, 4, 15'h0045, 15'h0045, 2'b00, 0, 0));

      idle();
      repeat (2) @(negedge clk);
      rst_l = 1'b1;

      for (int r = 0; r < 8; r++) begin
         @(negedge clk);
         idle();
         rd_req = 2'b11; rd_sel[0] = 3'(r); rd_sel[1] = 3'(r);
         #2;
         chk($sformatf("reset_data_r%0d", r), rd_data[0], 0);
         chk($sformatf("reset_stall_r%0d", r), stall, 0);
      end
      chk("reset_ovf", ovf, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         clear = vecs[i].clr;
         wr_en = vecs[i].we; wr_sel[0] = vecs[i].ws0; wr_sel[1] = vecs[i].ws1;
         wr_data[0] = vecs[i].wd0; wr_data[1] = vecs[i].wd1;
         rsv_en = vecs[i].re; rsv_sel[0] = vecs[i].rs0; rsv_sel[1] = vecs[i].rs1;
         rd_req = vecs[i].rq; rd_sel[0] = vecs[i].q0; rd_sel[1] = vecs[i].q1;
         #2;
         chk($sformatf("v%0d_rd_data0", i), rd_data[0], vecs[i].ed0);
         chk($sformatf("v%0d_rd_data1", i), rd_data[1], vecs[i].ed1);
         chk($sformatf("v%0d_rd_busy", i), rd_busy, vecs[i].eb);
         chk($sformatf("v%0d_stall", i), stall, vecs[i].es);
         chk($sformatf("v%0d_ovf", i), ovf, vecs[i].eo);
      end

      // Double reservations of r5 push the count past its limit, then reset mid-cycle
      @(negedge clk);
      idle();
      rsv_en = 2'b11; rsv_sel[0] = 3'd5; rsv_sel[1] = 3'd5;
      @(negedge clk);
      rd_sel[0] = 3'd5; rd_sel[1] = 3'd5;
      #2;
      chk("r5_busy_after_two", rd_busy, 2'b11);
      chk("r5_ovf_after_two", ovf, 0);
      @(negedge clk);
      rsv_en = '0;
      #2;
      chk("r5_ovf_after_four", ovf, 1);
      chk("r5_busy_after_four", rd_busy, 2'b11);
      rst_l = 1'b0;
      #1;
      chk("async_rst_busy", rd_busy, 2'b00);
      chk("async_rst_ovf", ovf, 0);
      rst_l = 1'b1;
      @(negedge clk);
      wr_en = 2'b01; wr_sel[0] = 3'd5; wr_data[0] = 15'h0055; rd_req = 2'b01;
      #2;
      chk("post_rst_wr_busy", rd_busy, 2'b00);
      chk("post_rst_wr_fwd", rd_data[0], 15'h0055);
      @(negedge clk);
      wr_en = '0;
      #2;
      chk("post_rst_busy", rd_busy, 2'b00);
      chk("post_rst_stall", stall, 0);
      chk("post_rst_ovf", ovf, 0);
      chk("post_rst_data", rd_data[1], 15'h0055);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
